// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : RV32I opcodes, immediate formats and decode helpers shared by
//               the decode stage and its immediate generator.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic branch;
    logic jump;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    ctrl_t ctrl;
    logic  uses_rs1;
    logic  uses_rs2;
  } decode_t;

  function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

  // Unknown opcodes fall through with every control bit clear.
  function automatic decode_t decode_opcode(input logic [6:0] opcode);
    decode_t d;
    d = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
      end
      OPC_JAL: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.jump      = 1'b1;
      end
      OPC_JALR: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.jump      = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.uses_rs1       = 1'b1;
      end
      OPC_BRANCH: begin
        d.ctrl.branch = 1'b1;
        d.uses_rs1    = 1'b1;
        d.uses_rs2    = 1'b1;
      end
      OPC_LOAD: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.mem_read  = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.uses_rs1       = 1'b1;
      end
      OPC_STORE: begin
        d.ctrl.mem_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.uses_rs1       = 1'b1;
        d.uses_rs2       = 1'b1;
      end
      OPC_OP_IMM: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.uses_rs1       = 1'b1;
      end
      OPC_OP: begin
        d.ctrl.reg_write = 1'b1;
        d.uses_rs1       = 1'b1;
        d.uses_rs2       = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : IF/ID, RegisterFile, WB and ID/EX signal bundle of the decode
//               stage; slave = decode stage, master = surrounding pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 ifIdValid;
  logic [31:0]          ifIdInstr;
  logic [XLEN-1:0]      ifIdPc;
  logic                 flush;
  logic [4:0]           readReg1;
  logic [4:0]           readReg2;
  logic [XLEN-1:0]      readData1;
  logic [XLEN-1:0]      readData2;
  logic                 wbWriteEnable;
  logic [4:0]           wbWriteReg;
  logic [XLEN-1:0]      wbWriteData;
  logic                 stall;
  logic                 idExValid;
  logic [XLEN-1:0]      idExPc;
  logic [XLEN-1:0]      idExRs1Data;
  logic [XLEN-1:0]      idExRs2Data;
  logic [XLEN-1:0]      idExImm;
  logic [4:0]           idExRs1;
  logic [4:0]           idExRs2;
  logic [4:0]           idExRd;
  logic [3:0]           idExFunct;
  logic                 idExRegWrite;
  logic                 idExMemRead;
  logic                 idExMemWrite;
  logic                 idExAluSrc;
  logic                 idExBranch;
  logic                 idExJump;
  logic [CNT_WIDTH-1:0] stallCount;

  modport slave (
    input  ifIdValid, ifIdInstr, ifIdPc, flush, readData1, readData2,
           wbWriteEnable, wbWriteReg, wbWriteData,
    output readReg1, readReg2, stall, idExValid, idExPc, idExRs1Data, idExRs2Data,
           idExImm, idExRs1, idExRs2, idExRd, idExFunct, idExRegWrite, idExMemRead,
           idExMemWrite, idExAluSrc, idExBranch, idExJump, stallCount
  );

  modport master (
    output ifIdValid, ifIdInstr, ifIdPc, flush, readData1, readData2,
           wbWriteEnable, wbWriteReg, wbWriteData,
    input  readReg1, readReg2, stall, idExValid, idExPc, idExRs1Data, idExRs2Data,
           idExImm, idExRs1, idExRs2, idExRd, idExFunct, idExRegWrite, idExMemRead,
           idExMemWrite, idExAluSrc, idExBranch, idExJump, stallCount
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational RV32I immediate extraction, format chosen by
//               opcode, sign-extended from instr[31] to XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);
  imm_fmt_e    fmt;
  logic [31:0] imm32;

  always_comb begin
    fmt   = imm_format(instr[6:0]);
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = XLEN'($signed(imm32));
  end
endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : RV32I decode, load-use/WB hazard detection and ID/EX register.
//               ID_WB_BYPASS_EN: forward the WB write into ID instead of stalling.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import rv32_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);
  logic [31:0]          instr;
  logic [4:0]           rs1, rs2, rd;
  logic [3:0]           funct;
  decode_t              dec;
  logic [XLEN-1:0]      imm;
  logic [XLEN-1:0]      op1, op2;
  logic                 hz_load, hz_wb, hz, stall;

  logic                 id_ex_valid_d, id_ex_valid_q;
  logic [XLEN-1:0]      id_ex_pc_d, id_ex_pc_q;
  logic [XLEN-1:0]      id_ex_rs1_data_d, id_ex_rs1_data_q;
  logic [XLEN-1:0]      id_ex_rs2_data_d, id_ex_rs2_data_q;
  logic [XLEN-1:0]      id_ex_imm_d, id_ex_imm_q;
  logic [4:0]           id_ex_rs1_d, id_ex_rs1_q;
  logic [4:0]           id_ex_rs2_d, id_ex_rs2_q;
  logic [4:0]           id_ex_rd_d, id_ex_rd_q;
  logic [3:0]           id_ex_funct_d, id_ex_funct_q;
  ctrl_t                id_ex_ctrl_d, id_ex_ctrl_q;
  logic [CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;

  assign instr        = bus.ifIdInstr;
  assign rs1          = instr[19:15];
  assign rs2          = instr[24:20];
  assign rd           = instr[11:7];
  assign funct        = {instr[30], instr[14:12]};
  assign dec          = decode_opcode(instr[6:0]);
  assign bus.readReg1 = rs1;
  assign bus.readReg2 = rs2;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr),
    .imm   (imm)
  );

  // The RegisterFile does not hardwire x0, so zero is forced here and wins over the bypass.
  always_comb begin
    op1 = (rs1 == 5'd0) ? '0 : bus.readData1;
    op2 = (rs2 == 5'd0) ? '0 : bus.readData2;
`ifdef ID_WB_BYPASS_EN
    if ((rs1 != 5'd0) && bus.wbWriteEnable && (bus.wbWriteReg == rs1)) op1 = bus.wbWriteData;
    if ((rs2 != 5'd0) && bus.wbWriteEnable && (bus.wbWriteReg == rs2)) op2 = bus.wbWriteData;
`endif
  end

  assign hz_load = id_ex_valid_q & id_ex_ctrl_q.mem_read & (id_ex_rd_q != 5'd0)
                 & ((dec.uses_rs1 & (id_ex_rd_q == rs1)) | (dec.uses_rs2 & (id_ex_rd_q == rs2)));

`ifdef ID_WB_BYPASS_EN
  assign hz_wb = 1'b0;
`else
  // Same-cycle RegisterFile read returns stale data; wait one cycle for the write to land.
  assign hz_wb = bus.wbWriteEnable & (bus.wbWriteReg != 5'd0)
               & ((dec.uses_rs1 & (bus.wbWriteReg == rs1)) | (dec.uses_rs2 & (bus.wbWriteReg == rs2)));
  logic unused_wb_data;
  assign unused_wb_data = ^bus.wbWriteData;
`endif

  assign hz        = bus.ifIdValid & (hz_load | hz_wb);
  assign stall     = hz & ~bus.flush;
  assign bus.stall = stall;

  always_comb begin
    id_ex_valid_d    = 1'b0;
    id_ex_pc_d       = '0;
    id_ex_rs1_data_d = '0;
    id_ex_rs2_data_d = '0;
    id_ex_imm_d      = '0;
    id_ex_rs1_d      = '0;
    id_ex_rs2_d      = '0;
    id_ex_rd_d       = '0;
    id_ex_funct_d    = '0;
    id_ex_ctrl_d     = CTRL_BUBBLE;
    if (!bus.flush && !stall && bus.ifIdValid) begin
      id_ex_valid_d    = 1'b1;
      id_ex_pc_d       = bus.ifIdPc;
      id_ex_rs1_data_d = op1;
      id_ex_rs2_data_d = op2;
      id_ex_imm_d      = imm;
      id_ex_rs1_d      = rs1;
      id_ex_rs2_d      = rs2;
      id_ex_rd_d       = rd;
      id_ex_funct_d    = funct;
      id_ex_ctrl_d     = dec.ctrl;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_valid_q    <= 1'b0;
      id_ex_pc_q       <= '0;
      id_ex_rs1_data_q <= '0;
      id_ex_rs2_data_q <= '0;
      id_ex_imm_q      <= '0;
      id_ex_rs1_q      <= '0;
      id_ex_rs2_q      <= '0;
      id_ex_rd_q       <= '0;
      id_ex_funct_q    <= '0;
      id_ex_ctrl_q     <= CTRL_BUBBLE;
      stall_cnt_q      <= '0;
    end else begin
      id_ex_valid_q    <= id_ex_valid_d;
      id_ex_pc_q       <= id_ex_pc_d;
      id_ex_rs1_data_q <= id_ex_rs1_data_d;
      id_ex_rs2_data_q <= id_ex_rs2_data_d;
      id_ex_imm_q      <= id_ex_imm_d;
      id_ex_rs1_q      <= id_ex_rs1_d;
      id_ex_rs2_q      <= id_ex_rs2_d;
      id_ex_rd_q       <= id_ex_rd_d;
      id_ex_funct_q    <= id_ex_funct_d;
      id_ex_ctrl_q     <= id_ex_ctrl_d;
      stall_cnt_q      <= stall_cnt_d;
    end
  end

  assign bus.idExValid    = id_ex_valid_q;
  assign bus.idExPc       = id_ex_pc_q;
  assign bus.idExRs1Data  = id_ex_rs1_data_q;
  assign bus.idExRs2Data  = id_ex_rs2_data_q;
  assign bus.idExImm      = id_ex_imm_q;
  assign bus.idExRs1      = id_ex_rs1_q;
  assign bus.idExRs2      = id_ex_rs2_q;
  assign bus.idExRd       = id_ex_rd_q;
  assign bus.idExFunct    = id_ex_funct_q;
  assign bus.idExRegWrite = id_ex_ctrl_q.reg_write;
  assign bus.idExMemRead  = id_ex_ctrl_q.mem_read;
  assign bus.idExMemWrite = id_ex_ctrl_q.mem_write;
  assign bus.idExAluSrc   = id_ex_ctrl_q.alu_src;
  assign bus.idExBranch   = id_ex_ctrl_q.branch;
  assign bus.idExJump     = id_ex_ctrl_q.jump;
  assign bus.stallCount   = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: vector table plus
//               hand-written WB hazard, saturation and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
  localparam int CW = 4;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, OPI = 7'b0010011, OPR = 7'b0110011, JALR = 7'b1100111;
  // {regWrite, memRead, memWrite, aluSrc, branch, jump}
  localparam logic [5:0] C_ALUI = 6'b100100, C_OP = 6'b100000, C_LD = 6'b110100;
  localparam logic [5:0] C_ST = 6'b001100, C_BR = 6'b000010, C_JAL = 6'b100001, C_JALR = 6'b100101;
  localparam int NV = 22;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .CNT_WIDTH(CW)) bus ();
  id_ex_stage #(.XLEN(32), .CNT_WIDTH(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] regs [32];
  assign bus.readData1 = regs[bus.readReg1];
  assign bus.readData2 = regs[bus.readReg2];

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
    logic [5:0]  ctrl;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    bit          valid;
    bit          flush;
    bit          stl;
    logic [31:0] imm;
    logic [5:0]  ctrl;
  } vec_t;

  vec_t tbl [NV];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPR};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], STORE};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] rf(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : regs[idx];
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] pc, input logic [31:0] instr,
                                  input logic [31:0] imm, input logic [5:0] ctrl);
    exp_t e;
    e.valid = 1'b1;
    e.pc    = pc;
    e.rs1   = instr[19:15];
    e.rs2   = instr[24:20];
    e.rd    = instr[11:7];
    e.rs1d  = rf(e.rs1);
    e.rs2d  = rf(e.rs2);
    e.imm   = imm;
    e.funct = {instr[30], instr[14:12]};
    e.ctrl  = ctrl;
    return e;
  endfunction

  function automatic exp_t get_act();
    exp_t a;
    a.valid = bus.idExValid;
    a.pc    = bus.idExPc;
    a.rs1d  = bus.idExRs1Data;
    a.rs2d  = bus.idExRs2Data;
    a.imm   = bus.idExImm;
    a.rs1   = bus.idExRs1;
    a.rs2   = bus.idExRs2;
    a.rd    = bus.idExRd;
    a.funct = bus.idExFunct;
    a.ctrl  = {bus.idExRegWrite, bus.idExMemRead, bus.idExMemWrite,
               bus.idExAluSrc, bus.idExBranch, bus.idExJump};
    return a;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] instr, input bit valid, input bit flush,
                         input bit stl, input logic [31:0] imm, input logic [5:0] ctrl);
    tbl[i].instr = instr;
    tbl[i].valid = valid;
    tbl[i].flush = flush;
    tbl[i].stl   = stl;
    tbl[i].imm   = imm;
    tbl[i].ctrl  = ctrl;
  endtask

  // One ID cycle: drive, check stall, push expectation, then pop and compare after the edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input bit valid, input bit flush,
                       input bit exp_stall, input exp_t exp, input string name);
    exp_t act;
    bus.ifIdInstr = instr;
    bus.ifIdPc    = pc;
    bus.ifIdValid = valid;
    bus.flush     = flush;
    sb.push_back(exp);
    #1;
    check({name, ".stall"}, 160'(bus.stall), 160'(exp_stall));
    if (exp_stall && exp_cnt < (1 << CW) - 1) exp_cnt++;
    @(posedge clk);
    if (bus.wbWriteEnable) regs[bus.wbWriteReg] = bus.wbWriteData;
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got output with no expectation", name);
    end else begin
      act = get_act();
      check(name, act, sb.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t        e;
    exp_t        bub;
    logic [31:0] ins;
    logic [31:0] ins2;

    bub   = '0;
    rst_n = 1'b0;
    bus.ifIdValid     = 1'b0;
    bus.ifIdInstr     = '0;
    bus.ifIdPc        = '0;
    bus.flush         = 1'b0;
    bus.wbWriteEnable = 1'b0;
    bus.wbWriteReg    = '0;
    bus.wbWriteData   = '0;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'hBAD0_0000 : 32'h1000_0000 + 32'(i) * 32'h11;

    set_vec(0,  enc_i(12'd7, 5'd0, 3'd0, 5'd5, OPI),           1, 0, 0, 32'd7,        C_ALUI);
    set_vec(1,  enc_i(12'd0, 5'd1, 3'b010, 5'd6, LOAD),        1, 0, 0, 32'd0,        C_LD);
    set_vec(2,  enc_r(7'd0, 5'd2, 5'd6, 3'd0, 5'd7),           1, 0, 1, 32'd0,        C_OP);
    set_vec(3,  enc_r(7'd0, 5'd2, 5'd6, 3'd0, 5'd7),           1, 0, 0, 32'd0,        C_OP);
    set_vec(4,  enc_i(12'd4, 5'd1, 3'b010, 5'd0, LOAD),        1, 0, 0, 32'd4,        C_LD);
    set_vec(5,  enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd9),           1, 0, 0, 32'd0,        C_OP);
    set_vec(6,  enc_i(12'd8, 5'd2, 3'b010, 5'd10, LOAD),       1, 0, 0, 32'd8,        C_LD);
    set_vec(7,  enc_r(7'h20, 5'd3, 5'd10, 3'd0, 5'd11),        1, 1, 0, 32'd0,        C_OP);
    set_vec(8,  enc_b(13'h1FF8, 5'd2, 5'd1),                   1, 0, 0, 32'hFFFFFFF8, C_BR);
    set_vec(9,  enc_j(21'h000800, 5'd1),                       1, 0, 0, 32'h00000800, C_JAL);
    set_vec(10, enc_u(20'hABCDE, 5'd12, LUI),                  1, 0, 0, 32'hABCDE000, C_ALUI);
    set_vec(11, enc_s(12'd12, 5'd5, 5'd4),                     1, 0, 0, 32'd12,       C_ST);
    set_vec(12, enc_i(12'hFFC, 5'd5, 3'd0, 5'd1, JALR),        1, 0, 0, 32'hFFFFFFFC, C_JALR);
    set_vec(13, enc_u(20'h12345, 5'd13, AUIPC),                1, 0, 0, 32'h12345000, C_ALUI);
    set_vec(14, 32'h1234_567F,                                 1, 0, 0, 32'd0,        6'b000000);
    set_vec(15, enc_i(12'd1, 5'd1, 3'd0, 5'd1, OPI),           0, 0, 0, 32'd0,        6'b000000);
    set_vec(16, enc_i(12'h403, 5'd5, 3'b101, 5'd14, OPI),      1, 0, 0, 32'h00000403, C_ALUI);
    set_vec(17, enc_i(12'd0, 5'd0, 3'b010, 5'd15, LOAD),       1, 0, 0, 32'd0,        C_LD);
    set_vec(18, enc_s(12'd0, 5'd15, 5'd1),                     1, 0, 1, 32'd0,        C_ST);
    set_vec(19, enc_s(12'd0, 5'd15, 5'd1),                     1, 0, 0, 32'd0,        C_ST);
    set_vec(20, enc_i(12'd0, 5'd0, 3'b010, 5'd16, LOAD),       1, 0, 0, 32'd0,        C_LD);
    set_vec(21, enc_u(20'h00001, 5'd16, LUI),                  1, 0, 0, 32'h00001000, C_ALUI);

    // Reset: outputs cleared, stall follows its equation with an empty ID/EX.
    repeat (2) @(posedge clk);
    #1;
    bus.ifIdValid = 1'b1;
    bus.ifIdInstr = tbl[3].instr;
    #1;
    check("reset.outputs", get_act(), 160'(bub));
    check("reset.stallCount", 160'(bus.stallCount), 160'(0));
    check("reset.stall", 160'(bus.stall), 160'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      logic [31:0] pc;
      pc = 32'h1000 + 32'(i) * 32'd4;
      if (tbl[i].valid && !tbl[i].flush && !tbl[i].stl) e = mk_exp(pc, tbl[i].instr, tbl[i].imm, tbl[i].ctrl);
      else e = bub;
      issue(tbl[i].instr, pc, tbl[i].valid, tbl[i].flush, tbl[i].stl, e, $sformatf("vec%0d", i));
    end
    check("table.stallCount", 160'(bus.stallCount), 160'(exp_cnt));

    // WB write to a source register in the same cycle as its read.
    ins = enc_r(7'd0, 5'd3, 5'd3, 3'd0, 5'd8);
    bus.wbWriteEnable = 1'b1;
    bus.wbWriteReg    = 5'd3;
    bus.wbWriteData   = 32'h0000DEAD;
`ifdef ID_WB_BYPASS_EN
    e = mk_exp(32'h2000, ins, 32'd0, C_OP);
    e.rs1d = 32'h0000DEAD;
    e.rs2d = 32'h0000DEAD;
    issue(ins, 32'h2000, 1, 0, 0, e, "wb.bypass");
    bus.wbWriteEnable = 1'b0;
`else
    issue(ins, 32'h2000, 1, 0, 1, bub, "wb.stall");
    bus.wbWriteEnable = 1'b0;
    e = mk_exp(32'h2000, ins, 32'd0, C_OP);
    e.rs1d = 32'h0000DEAD;
    e.rs2d = 32'h0000DEAD;
    issue(ins, 32'h2000, 1, 0, 0, e, "wb.after");
`endif
    check("wb.stallCount", 160'(bus.stallCount), 160'(exp_cnt));

    // A WB write to x0 never stalls and never leaks into an x0 operand.
    ins = enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd8);
    bus.wbWriteEnable = 1'b1;
    bus.wbWriteReg    = 5'd0;
    bus.wbWriteData   = 32'h0000BEEF;
    issue(ins, 32'h2004, 1, 0, 0, mk_exp(32'h2004, ins, 32'd0, C_OP), "wb.x0");
    bus.wbWriteEnable = 1'b0;

    // Repeated load-use stalls until the counter saturates.
    ins  = enc_i(12'd0, 5'd1, 3'b010, 5'd6, LOAD);
    ins2 = enc_r(7'd0, 5'd2, 5'd6, 3'd0, 5'd7);
    for (int k = 0; k < 16; k++) begin
      issue(ins, 32'h3000, 1, 0, 0, mk_exp(32'h3000, ins, 32'd0, C_LD), $sformatf("sat%0d.lw", k));
      issue(ins2, 32'h3004, 1, 0, 1, bub, $sformatf("sat%0d.stall", k));
      issue(ins2, 32'h3004, 1, 0, 0, mk_exp(32'h3004, ins2, 32'd0, C_OP), $sformatf("sat%0d.add", k));
    end
    check("sat.model", 160'(bus.stallCount), 160'(exp_cnt));
    check("sat.allones", 160'(bus.stallCount), 160'(4'hF));

    // Reset asserted while a load-use stall is pending.
    issue(ins, 32'h4000, 1, 0, 0, mk_exp(32'h4000, ins, 32'd0, C_LD), "rstmid.lw");
    bus.ifIdInstr = ins2;
    bus.ifIdPc    = 32'h4004;
    bus.ifIdValid = 1'b1;
    #1;
    check("rstmid.stall_before", 160'(bus.stall), 160'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid.outputs", get_act(), 160'(bub));
    check("rstmid.stall", 160'(bus.stall), 160'(0));
    check("rstmid.stallCount", 160'(bus.stallCount), 160'(0));
    exp_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(ins2, 32'h4004, 1, 0, 0, mk_exp(32'h4004, ins2, 32'd0, C_OP), "rstmid.reissue");
    check("rstmid.stallCount_after", 160'(bus.stallCount), 160'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
